// File: rtl/lsu_data_port_pkg.sv
// Shared memory-access types and the LSU state encoding for the RV32I memory stage.
package lsu_data_port_pkg;

  typedef enum logic [3:0] {
    LB   = 4'h0,
    LH   = 4'h1,
    LW   = 4'h2,
    LBU  = 4'h4,
    LHU  = 4'h5,
    SB   = 4'h8,
    SH   = 4'h9,
    SW   = 4'hA,
    NONE = 4'hF
  } mem_access_type;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } lsu_state;

  // Halfwords need addr[0]=0, words need addr[1:0]=0; bytes are always aligned.
  function automatic logic is_misaligned(mem_access_type access, logic [1:0] off);
    case (access)
      LH, LHU, SH: return off[0];
      LW, SW:      return off != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and extract/extend for loads; purely combinational.
module lsu_align
  import lsu_data_port_pkg::*;
(
  input  mem_access_type access,
  input  logic [1:0]     offset,
  input  logic [31:0]    wdata,
  input  logic [31:0]    rword,
  output logic [3:0]     wstrb,
  output logic [31:0]    wdata_pos,
  output logic [31:0]    rdata_ext,
  output logic           misaligned
);

  logic [31:0] word;

  always_comb begin
    wstrb      = '0;
    wdata_pos  = '0;
    rdata_ext  = '0;
    misaligned = is_misaligned(access, offset);
    word       = rword >> {offset, 3'b000};
    case (access)
      SB: begin
        wstrb     = 4'b0001 << offset;
        wdata_pos = {4{wdata[7:0]}};
      end
      SH: begin
        wstrb     = 4'b0011 << offset;
        wdata_pos = {2{wdata[15:0]}};
      end
      SW: begin
        wstrb     = 4'hF;
        wdata_pos = wdata;
      end
      LB:      rdata_ext = {{24{word[7]}}, word[7:0]};
      LBU:     rdata_ext = {24'h0, word[7:0]};
      LH:      rdata_ext = {{16{word[15]}}, word[15:0]};
      LHU:     rdata_ext = {16'h0, word[15:0]};
      LW:      rdata_ext = word;
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_data_port.sv
// Memory-stage load/store unit: one op at a time over a req/gnt/rvalid data port.
module lsu_data_port
  import lsu_data_port_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [3:0]            req_access,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_data,
  output logic                  resp_misaligned,
  output logic                  mem_req,
  input  logic                  mem_gnt,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [3:0]            mem_wstrb,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata
);

  lsu_state              state_q, state_d;
  mem_access_type        req_kind, access_q, al_access;
  logic [1:0]            off_q, al_offset;
  logic [3:0]            al_wstrb;
  logic [31:0]           al_wdata, al_rdata;
  logic                  al_mis;
  logic                  req_is_mem, req_is_store;
  logic [31:0]           resp_data_q;
  logic                  resp_mis_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic                  mem_we_q;
  logic [3:0]            mem_wstrb_q;
  logic [31:0]           mem_wdata_q;

  assign req_kind     = mem_access_type'(req_access);
  assign req_is_mem   = req_kind inside {LB, LH, LW, LBU, LHU, SB, SH, SW};
  assign req_is_store = req_kind inside {SB, SH, SW};

  // One aligner serves both phases: it sees the incoming op while idle (to decide
  // misalignment and lane positions) and the captured op afterwards (to extract loads).
  assign al_access = (state_q == IDLE) ? req_kind : access_q;
  assign al_offset = (state_q == IDLE) ? req_addr[1:0] : off_q;

  lsu_align u_align (
    .access     (al_access),
    .offset     (al_offset),
    .wdata      (req_wdata),
    .rword      (mem_rdata),
    .wstrb      (al_wstrb),
    .wdata_pos  (al_wdata),
    .rdata_ext  (al_rdata),
    .misaligned (al_mis)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_valid) state_d = (req_is_mem && !al_mis) ? REQ : RESP;
      REQ:  if (mem_gnt)   state_d = mem_we_q ? RESP : WAIT;
      WAIT: if (mem_rvalid) state_d = RESP;
      RESP: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      access_q    <= NONE;
      off_q       <= '0;
      resp_data_q <= '0;
      resp_mis_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wstrb_q <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (req_valid) begin
          access_q    <= req_kind;
          off_q       <= req_addr[1:0];
          resp_data_q <= '0;
          resp_mis_q  <= req_is_mem && al_mis;
          if (state_d == REQ) begin
            mem_addr_q  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_we_q    <= req_is_store;
            mem_wstrb_q <= al_wstrb;
            mem_wdata_q <= al_wdata;
          end
        end
        WAIT: if (mem_rvalid) resp_data_q <= al_rdata;
        default: ;
      endcase
    end
  end

  assign req_ready       = (state_q == IDLE);
  assign resp_valid      = (state_q == RESP);
  assign resp_data       = resp_data_q;
  assign resp_misaligned = resp_mis_q;
  assign mem_req         = (state_q == REQ);
  assign mem_addr        = mem_addr_q;
  assign mem_we          = mem_we_q;
  assign mem_wstrb       = mem_wstrb_q;
  assign mem_wdata       = mem_wdata_q;

endmodule

// File: tb/tb_lsu_data_port.sv
// Bench for lsu_data_port: directed spot checks plus randomized ops against an arithmetic model.
module tb_lsu_data_port;
  import lsu_data_port_pkg::*;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, resp_valid, resp_ready, resp_misaligned;
  logic [3:0]  req_access, mem_wstrb;
  logic [31:0] req_addr, req_wdata, resp_data, mem_addr, mem_wdata, mem_rdata;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lsu_data_port #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_access(req_access),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_misaligned(resp_misaligned),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic [31:0] data;
    logic        mis;
    logic        mem;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    int          lat;
  } exp_t;

  typedef struct {
    logic [31:0] data;
    logic        mis;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] addr;
    int          req_cycles;
    int          lat;
    logic        mem_unstable;
    logic        resp_unstable;
    logic        ready_seen;
    logic        timeout;
  } obs_t;

  // Expected outcome from access size and byte offset; gd/rv are the grant and rvalid delays.
  function automatic exp_t model(mem_access_type k, logic [31:0] a, logic [31:0] wd,
                                 logic [31:0] rd, int gd, int rv);
    exp_t        e;
    int          size, off;
    logic [31:0] mask, val;
    e = '{data: 0, mis: 0, mem: 0, we: 0, wstrb: 0, wdata: 0, lat: 1};
    off = int'(a[1:0]);
    case (k)
      LB, LBU, SB: size = 1;
      LH, LHU, SH: size = 2;
      LW, SW:      size = 4;
      default:     size = 0;
    endcase
    if (size == 0) return e;
    if (off % size != 0) begin
      e.mis = 1'b1;
      return e;
    end
    e.mem = 1'b1;
    if (k inside {SB, SH, SW}) begin
      e.we    = 1'b1;
      e.wstrb = 4'(((1 << size) - 1) << off);
      e.wdata = (size == 1) ? 32'(wd[7:0]) * 32'h01010101 :
                (size == 2) ? 32'(wd[15:0]) * 32'h00010001 : wd;
      e.lat   = 2 + gd;
    end else begin
      mask = (size == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * size)) - 32'd1;
      val  = (rd >> (8 * off)) & mask;
      if ((k inside {LB, LH}) && val[8*size-1]) val = val | ~mask;
      e.data = val;
      e.lat  = 3 + gd + rv;
    end
    return e;
  endfunction

  // Drives one op from IDLE and records what the port did; comparisons live in the callers.
  task automatic run_op(input mem_access_type k, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int gd, input int rv, input int rdy,
                        output obs_t o);
    int cyc, req_n, resp_n, gnt_at;
    bit done;
    o = '{data: 0, mis: 0, we: 0, wstrb: 0, wdata: 0, addr: 0, req_cycles: 0, lat: -1,
          mem_unstable: 0, resp_unstable: 0, ready_seen: 0, timeout: 0};
    req_valid = 1'b1; req_access = k; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_access = 4'($urandom); req_addr = $urandom; req_wdata = $urandom;
    cyc = 1; req_n = 0; resp_n = 0; gnt_at = -1; done = 0;
    while (!done && cyc < 40) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; resp_ready = 1'b0; mem_rdata = $urandom;
      if (req_ready) o.ready_seen = 1'b1;
      if (mem_req) begin
        if (req_n == 0) begin
          o.addr = mem_addr; o.we = mem_we; o.wstrb = mem_wstrb; o.wdata = mem_wdata;
        end else if ({mem_addr, mem_we, mem_wstrb, mem_wdata} !== {o.addr, o.we, o.wstrb, o.wdata})
          o.mem_unstable = 1'b1;
        if (req_n == gd) begin
          mem_gnt = 1'b1;
          gnt_at  = cyc;
        end
        req_n++;
      end
      if (gnt_at >= 0 && gnt_at != cyc && cyc == gnt_at + 1 + rv && (k inside {LB, LH, LW, LBU, LHU})) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rd;
      end
      if (resp_valid) begin
        if (resp_n == 0) begin
          o.lat = cyc; o.data = resp_data; o.mis = resp_misaligned;
        end else if ({resp_data, resp_misaligned} !== {o.data, o.mis})
          o.resp_unstable = 1'b1;
        if (resp_n == rdy) begin
          resp_ready = 1'b1;
          done = 1;
        end
        resp_n++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0; resp_ready = 1'b0;
    o.req_cycles = req_n;
    o.timeout = !done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({req_ready, resp_valid, resp_data, resp_misaligned, mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata}
        !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0}) begin
      n_bad++;
      $display("FAIL reset_outputs: got rdy=%b rv=%b data=%h mis=%b req=%b we=%b strb=%h addr=%h wd=%h",
               req_ready, resp_valid, resp_data, resp_misaligned, mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata);
    end
    // a request presented while reset is held must not be accepted
    req_valid = 1'b1; req_access = SW; req_addr = 32'h40; req_wdata = 32'h1234_5678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({mem_req, resp_valid, req_ready} !== 3'b001) begin
      n_bad++;
      $display("FAIL reset_wins: got req=%b rv=%b rdy=%b want 0 0 1", mem_req, resp_valid, req_ready);
    end
  endtask

  task automatic test_store();
    obs_t o;
    run_op(SW, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, 0, o);
    n_cmp++;
    if ({o.addr, o.we, o.wstrb, o.wdata, o.data} !== {32'h100, 1'b1, 4'hF, 32'hDEADBEEF, 32'h0}) begin
      n_bad++;
      $display("FAIL sw_port: got addr=%h we=%b strb=%h wd=%h data=%h", o.addr, o.we, o.wstrb, o.wdata, o.data);
    end
    n_cmp++;
    if (o.lat !== 2) begin
      n_bad++;
      $display("FAIL sw_latency: got %0d want 2", o.lat);
    end
    run_op(SB, 32'h103, 32'h0000_00A5, 32'h0, 0, 0, 0, o);
    n_cmp++;
    if ({o.addr, o.we, o.wstrb, o.wdata} !== {32'h100, 1'b1, 4'b1000, 32'hA5A5A5A5}) begin
      n_bad++;
      $display("FAIL sb_port: got addr=%h we=%b strb=%h wd=%h", o.addr, o.we, o.wstrb, o.wdata);
    end
  endtask

  task automatic test_load();
    obs_t o;
    mem_access_type ks[3] = '{LB, LBU, LHU};
    logic [31:0]    want[3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_1280};
    for (int i = 0; i < 3; i++) begin
      run_op(ks[i], 32'h102, 32'h0, 32'h1280_3456, 0, 0, 0, o);
      n_cmp++;
      if ({o.data, o.mis, o.we, o.wstrb, o.addr} !== {want[i], 1'b0, 1'b0, 4'h0, 32'h100}) begin
        n_bad++;
        $display("FAIL load_%s: got data=%h mis=%b we=%b strb=%h addr=%h want data=%h",
                 ks[i].name(), o.data, o.mis, o.we, o.wstrb, o.addr, want[i]);
      end
      n_cmp++;
      if (o.lat !== 3) begin
        n_bad++;
        $display("FAIL load_latency: got %0d want 3", o.lat);
      end
    end
  endtask

  task automatic test_misaligned();
    obs_t o;
    mem_access_type ks[2] = '{LW, LH};
    logic [31:0]    as[2] = '{32'h101, 32'h103};
    for (int i = 0; i < 2; i++) begin
      run_op(ks[i], as[i], 32'h0, 32'hFFFF_FFFF, 0, 0, 0, o);
      n_cmp++;
      if ({o.mis, o.data, o.req_cycles != 0} !== {1'b1, 32'h0, 1'b0}) begin
        n_bad++;
        $display("FAIL misaligned_%s: got mis=%b data=%h req_cycles=%0d want 1 0 0",
                 ks[i].name(), o.mis, o.data, o.req_cycles);
      end
    end
  endtask

  task automatic test_stall();
    obs_t o;
    run_op(LW, 32'h200, 32'h0, 32'hCAFE_F00D, 3, 2, 2, o);
    n_cmp++;
    if ({o.mem_unstable, o.resp_unstable, o.ready_seen, o.timeout} !== 4'b0000) begin
      n_bad++;
      $display("FAIL stall_flags: got memunst=%b respunst=%b ready=%b timeout=%b want 0000",
               o.mem_unstable, o.resp_unstable, o.ready_seen, o.timeout);
    end
    n_cmp++;
    if ({o.data, o.addr, o.req_cycles} !== {32'hCAFE_F00D, 32'h200, 32'd4}) begin
      n_bad++;
      $display("FAIL stall_result: got data=%h addr=%h req_cycles=%0d want cafef00d 200 4",
               o.data, o.addr, o.req_cycles);
    end
    n_cmp++;
    if (o.lat !== 8) begin
      n_bad++;
      $display("FAIL stall_latency: got %0d want 8", o.lat);
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    req_valid = 1'b1; req_access = LW; req_addr = 32'h300; req_wdata = 32'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({req_ready, resp_valid, resp_data, resp_misaligned, mem_req, mem_we, mem_wstrb, mem_addr}
        !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0}) begin
      n_bad++;
      $display("FAIL reset_mid_outputs: got rdy=%b rv=%b data=%h mis=%b req=%b we=%b strb=%h addr=%h",
               req_ready, resp_valid, resp_data, resp_misaligned, mem_req, mem_we, mem_wstrb, mem_addr);
    end
    run_op(LW, 32'h304, 32'h0, 32'h0BAD_CAFE, 0, 0, 0, o);
    n_cmp++;
    if ({o.data, o.mis, o.addr, o.timeout} !== {32'h0BAD_CAFE, 1'b0, 32'h304, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_mid_next_lw: got data=%h mis=%b addr=%h timeout=%b", o.data, o.mis, o.addr, o.timeout);
    end
  endtask

  task automatic test_random();
    obs_t           o;
    exp_t           e;
    mem_access_type kinds[9] = '{LB, LH, LW, LBU, LHU, SB, SH, SW, NONE};
    mem_access_type k;
    logic [31:0]    a, wd, rd;
    int             gd, rv, rdy;
    for (int i = 0; i < 60; i++) begin
      k   = kinds[$urandom_range(0, 8)];
      a   = $urandom;
      wd  = $urandom;
      rd  = $urandom;
      gd  = $urandom_range(0, 3);
      rv  = $urandom_range(0, 3);
      rdy = $urandom_range(0, 2);
      e   = model(k, a, wd, rd, gd, rv);
      run_op(k, a, wd, rd, gd, rv, rdy, o);
      n_cmp++;
      if ({o.data, o.mis, o.req_cycles != 0, o.lat} !== {e.data, e.mis, e.mem, e.lat}) begin
        n_bad++;
        $display("FAIL rand_resp[%0d] %s a=%h: got data=%h mis=%b mem=%b lat=%0d want data=%h mis=%b mem=%b lat=%0d",
                 i, k.name(), a, o.data, o.mis, o.req_cycles != 0, o.lat, e.data, e.mis, e.mem, e.lat);
      end
      if (e.mem) begin
        n_cmp++;
        if ({o.addr, o.we, o.wstrb, o.wdata & {{8{o.wstrb[3]}}, {8{o.wstrb[2]}}, {8{o.wstrb[1]}}, {8{o.wstrb[0]}}}}
            !== {a & 32'hFFFF_FFFC, e.we, e.wstrb, e.wdata & {{8{e.wstrb[3]}}, {8{e.wstrb[2]}}, {8{e.wstrb[1]}}, {8{e.wstrb[0]}}}}) begin
          n_bad++;
          $display("FAIL rand_port[%0d] %s a=%h: got addr=%h we=%b strb=%h wd=%h want we=%b strb=%h wd=%h",
                   i, k.name(), a, o.addr, o.we, o.wstrb, o.wdata, e.we, e.wstrb, e.wdata);
        end
      end
      n_cmp++;
      if ({o.mem_unstable, o.resp_unstable, o.ready_seen, o.timeout} !== 4'b0000) begin
        n_bad++;
        $display("FAIL rand_handshake[%0d] %s: got memunst=%b respunst=%b ready=%b timeout=%b want 0000",
                 i, k.name(), o.mem_unstable, o.resp_unstable, o.ready_seen, o.timeout);
      end
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_access = NONE; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    test_reset();
    test_store();
    test_load();
    test_misaligned();
    test_stall();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
